// File: rtl/pong_pkg.sv
// Shared Pong constants: field geometry and paddle defaults for gameplay and paddle_ctrl.
package pong_pkg;

   localparam int unsigned FIELD_H     = 480;
   localparam int unsigned PADDLE_H    = 80;
   localparam int unsigned POS_W_DEF   = 9;
   localparam int unsigned POS_MAX_DEF = FIELD_H - PADDLE_H;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a consecutive-cycle debounce counter.
module btn_debounce #(
   parameter int unsigned DEB_CYCLES = 16
) (
   input  logic clk,
   input  logic clr_n,
   input  logic btn,
   output logic stable
);

   localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

   logic             sync1, sync2;
   logic [CNT_W-1:0] cnt;

   if (DEB_CYCLES < 1) begin : g_chk_deb
      $error("btn_debounce: DEB_CYCLES must be at least 1");
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         // the flip happens on the cycle the count would reach DEB_CYCLES
         if (sync2 != stable) begin
            if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
               stable <= sync2;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/paddle_ctrl.sv
// N-channel paddle controller: debounced buttons drive clamped, accelerating paddle positions.
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned NUM_PADDLES = 2,
   parameter int unsigned POS_W       = POS_W_DEF,
   parameter int unsigned POS_MAX     = POS_MAX_DEF,
   parameter int unsigned POS_RESET   = 200,
   parameter int unsigned DEB_CYCLES  = 16,
   parameter int unsigned STEP_SLOW   = 1,
   parameter int unsigned STEP_FAST   = 4,
   parameter int unsigned HOLD_TICKS  = 8
) (
   input  logic                         clk,
   input  logic                         clr_n,
   input  logic                         tick,
   input  logic                         freeze,
   input  logic                         recentre,
   input  logic [NUM_PADDLES-1:0]       btn_up,
   input  logic [NUM_PADDLES-1:0]       btn_down,
   output logic [NUM_PADDLES*POS_W-1:0] pos,
   output logic [NUM_PADDLES-1:0]       moving,
   output logic [NUM_PADDLES-1:0]       at_limit
);

   localparam int unsigned EXT_W  = POS_W + 1;
   localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

   localparam logic [EXT_W-1:0]  MAX_X   = EXT_W'(POS_MAX);
   localparam logic [EXT_W-1:0]  SLOW_X  = EXT_W'(STEP_SLOW);
   localparam logic [EXT_W-1:0]  FAST_X  = EXT_W'(STEP_FAST);
   localparam logic [POS_W-1:0]  MAX_P   = POS_W'(POS_MAX);
   localparam logic [POS_W-1:0]  RESET_P = POS_W'(POS_RESET);
   localparam logic [HOLD_W-1:0] HOLD_H  = HOLD_W'(HOLD_TICKS);

   if (POS_MAX >= (1 << POS_W)) begin : g_chk_max
      $error("paddle_ctrl: POS_MAX does not fit in POS_W bits");
   end
   if (POS_RESET > POS_MAX) begin : g_chk_reset
      $error("paddle_ctrl: POS_RESET exceeds POS_MAX");
   end
   if (STEP_SLOW < 1 || STEP_SLOW > STEP_FAST || STEP_FAST > POS_MAX) begin : g_chk_step
      $error("paddle_ctrl: need 1 <= STEP_SLOW <= STEP_FAST <= POS_MAX");
   end
   if (HOLD_TICKS < 1) begin : g_chk_hold
      $error("paddle_ctrl: HOLD_TICKS must be at least 1");
   end

   for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_pad
      logic              up_s, dn_s;
      dir_e              dir, prev_dir;
      logic [HOLD_W-1:0] hold, hold_nxt;
      logic [POS_W-1:0]  p, pos_nxt;
      logic [EXT_W-1:0]  p_x, step, sum;
      logic              mov;

      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
         .clk(clk), .clr_n(clr_n), .btn(btn_up[i]), .stable(up_s)
      );
      btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
         .clk(clk), .clr_n(clr_n), .btn(btn_down[i]), .stable(dn_s)
      );

      // step is chosen from the post-increment hold count, so the tick that
      // saturates the counter is already a fast one
      always_comb begin
         dir = DIR_NONE;
         if (up_s && !dn_s)      dir = DIR_UP;
         else if (dn_s && !up_s) dir = DIR_DOWN;

         hold_nxt = '0;
         if (dir != DIR_NONE && dir == prev_dir)
            hold_nxt = (hold == HOLD_H) ? hold : hold + 1'b1;

         step    = (hold_nxt == HOLD_H) ? FAST_X : SLOW_X;
         p_x     = {1'b0, p};
         sum     = p_x + step;
         pos_nxt = p;
         case (dir)
            DIR_UP:   pos_nxt = (p_x < step) ? '0 : POS_W'(p_x - step);
            DIR_DOWN: pos_nxt = (sum > MAX_X) ? MAX_P : sum[POS_W-1:0];
            default:  pos_nxt = p;
         endcase
      end

      always_ff @(posedge clk or negedge clr_n) begin
         if (!clr_n) begin
            p        <= RESET_P;
            mov      <= 1'b0;
            hold     <= '0;
            prev_dir <= DIR_NONE;
         end else if (recentre) begin
            p        <= RESET_P;
            mov      <= 1'b0;
            hold     <= '0;
            prev_dir <= DIR_NONE;
         end else if (freeze) begin
            hold     <= '0;
            prev_dir <= DIR_NONE;
            if (tick) mov <= 1'b0;
         end else if (tick) begin
            p        <= pos_nxt;
            mov      <= (pos_nxt != p);
            hold     <= hold_nxt;
            prev_dir <= dir;
         end
      end

      assign pos[i*POS_W +: POS_W] = p;
      assign moving[i]             = mov;
      assign at_limit[i]           = (p == '0) || (p == MAX_P);
   end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with default parameters and hand-computed positions.
module tb_paddle_ctrl;

   logic        clk = 1'b0;
   logic        clr_n, tick, freeze, recentre;
   logic [1:0]  btn_up, btn_down;
   logic [17:0] pos;
   logic [1:0]  moving, at_limit;
   logic [8:0]  p0, p1;

   int checks = 0;
   int errors = 0;
   int acc_exp [12] = '{199, 198, 197, 196, 195, 194, 193, 192, 188, 184, 180, 176};

   paddle_ctrl dut (
      .clk(clk), .clr_n(clr_n), .tick(tick), .freeze(freeze), .recentre(recentre),
      .btn_up(btn_up), .btn_down(btn_down), .pos(pos), .moving(moving), .at_limit(at_limit)
   );

   always #5 clk = ~clk;

   assign p0 = pos[8:0];
   assign p1 = pos[17:9];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   initial begin
      clr_n = 1'b0; tick = 1'b0; freeze = 1'b0; recentre = 1'b0;
      btn_up = 2'b00; btn_down = 2'b00;

      // reset and idle
      cyc(3);
      chk("rst_p0", p0, 200);
      chk("rst_p1", p1, 200);
      chk("rst_moving", moving, 0);
      chk("rst_at_limit", at_limit, 0);
      clr_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(9);
         do_tick();
         chk("idle_p0", p0, 200);
         chk("idle_p1", p1, 200);
         chk("idle_moving", moving, 0);
         chk("idle_at_limit", at_limit, 0);
      end

      // 5-cycle glitches never reach the debounce threshold
      for (int k = 0; k < 4; k++) begin
         btn_down[0] = 1'b1; cyc(5);
         btn_down[0] = 1'b0; cyc(5);
      end
      cyc(20);
      do_tick();
      chk("glitch_p0", p0, 200);
      chk("glitch_moving", moving, 0);

      // steady press: tick sampled on edge 18 still sees old stable value
      btn_down[0] = 1'b1;
      cyc(17);
      do_tick();
      chk("deb_early_p0", p0, 200);
      do_tick();
      chk("deb_p0", p0, 201);
      chk("deb_moving", moving, 2'b01);
      chk("deb_p1", p1, 200);
      do_tick();
      chk("deb_p0_b", p0, 202);
      btn_down[0] = 1'b0;
      cyc(20);

      // acceleration on paddle 1
      btn_up[1] = 1'b1;
      cyc(20);
      for (int k = 0; k < 12; k++) begin
         do_tick();
         chk("acc_p1", p1, acc_exp[k]);
      end
      chk("acc_p0", p0, 202);
      btn_up[1] = 1'b0; btn_down[1] = 1'b1;
      cyc(20);
      do_tick();
      chk("rev_p1", p1, 177);
      chk("rev_moving", moving, 2'b10);
      do_tick();
      chk("rev_p1_b", p1, 178);
      btn_down[1] = 1'b0;
      cyc(20);

      // clamp at POS_MAX from 398 with step 4
      btn_down[0] = 1'b1;
      cyc(20);
      repeat (55) do_tick();
      chk("clamp_hi_pre", p0, 398);
      chk("clamp_hi_pre_lim", at_limit, 2'b00);
      do_tick();
      chk("clamp_hi_p0", p0, 400);
      chk("clamp_hi_lim", at_limit, 2'b01);
      chk("clamp_hi_mov", moving, 2'b01);
      do_tick();
      chk("clamp_hi_p0_b", p0, 400);
      chk("clamp_hi_mov_b", moving, 2'b00);

      // clamp at 0 from 2 with step 4
      btn_down[0] = 1'b0; btn_up[1] = 1'b1;
      cyc(20);
      repeat (50) do_tick();
      chk("clamp_lo_pre", p1, 2);
      do_tick();
      chk("clamp_lo_p1", p1, 0);
      chk("clamp_lo_lim", at_limit, 2'b11);
      chk("clamp_lo_mov", moving, 2'b10);
      do_tick();
      chk("clamp_lo_mov_b", moving, 2'b00);

      // recentre wins over a tick in the same cycle
      btn_up[1] = 1'b0; btn_down[1] = 1'b1;
      cyc(20);
      do_tick();
      chk("pre_rc_p1", p1, 1);
      chk("pre_rc_mov", moving, 2'b10);
      recentre = 1'b1; tick = 1'b1;
      @(posedge clk); #1;
      recentre = 1'b0; tick = 1'b0;
      chk("rc_p0", p0, 200);
      chk("rc_p1", p1, 200);
      chk("rc_mov", moving, 2'b00);
      chk("rc_lim", at_limit, 2'b00);

      // freeze holds position, clears hold; press during freeze acts afterwards
      repeat (10) do_tick();
      chk("frz_pre_p1", p1, 216);
      freeze = 1'b1; btn_up[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc(3);
         do_tick();
         chk("frz_p1", p1, 216);
      end
      chk("frz_p0", p0, 200);
      chk("frz_mov", moving, 2'b00);
      freeze = 1'b0;
      do_tick();
      chk("unfrz_p1", p1, 217);
      chk("unfrz_p0", p0, 199);
      chk("unfrz_mov", moving, 2'b11);
      btn_up[0] = 1'b0;

      // both buttons: no movement, hold cleared
      btn_up[1] = 1'b1;
      cyc(20);
      for (int k = 0; k < 3; k++) begin
         do_tick();
         chk("both_p1", p1, 217);
         chk("both_mov", moving, 2'b00);
      end
      btn_up[1] = 1'b0;
      cyc(20);
      do_tick();
      chk("both_rel_p1", p1, 218);
      chk("both_p0", p0, 199);

      // reset mid-acceleration
      repeat (10) do_tick();
      chk("accel2_p1", p1, 237);
      #2 clr_n = 1'b0;
      #1;
      chk("async_rst_p1", p1, 200);
      chk("async_rst_p0", p0, 200);
      chk("async_rst_mov", moving, 2'b00);
      @(posedge clk); #1;
      clr_n = 1'b1;
      cyc(17);
      do_tick();
      chk("rst_redeb_early", p1, 200);
      do_tick();
      chk("rst_redeb_p1", p1, 201);
      chk("rst_redeb_mov", moving, 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
